// File: rtl/ff_mode_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ff_mode_bank
//  Description : WIDTH-bit register bank acting as D/T/JK/SR flip-flops chosen
//                by a shared run-time mode, with SR excitation outputs.
//                Optional macro FF_MODE_SR_CHECK_EN: S=R=1 holds and sets err.
//  Revision    : 1.0 - initial release
// ============================================================================
module ff_mode_bank #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [WIDTH-1:0] s_exc,
   output logic [WIDTH-1:0] r_exc,
   output logic             err
);

   localparam logic [1:0] c_MODE_D  = 2'b00;
   localparam logic [1:0] c_MODE_T  = 2'b01;
   localparam logic [1:0] c_MODE_JK = 2'b10;
   localparam logic [1:0] c_MODE_SR = 2'b11;

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_nxt;

   always_comb begin
      w_nxt = r_q;
      if (en) begin
         case (mode)
            c_MODE_D:  w_nxt = a;
            c_MODE_T:  w_nxt = r_q ^ a;
            c_MODE_JK: w_nxt = (a & ~r_q) | (~b & r_q);
            c_MODE_SR: begin
`ifdef FF_MODE_SR_CHECK_EN
               // S=R equal (both 0 or both 1) keeps the bit
               w_nxt = (a & ~b) | (r_q & ~(a ^ b));
`else
               // S=R=1 falls through to reset-dominant clear
               w_nxt = (a & ~b) | (r_q & ~a & ~b);
`endif
            end
            default:   w_nxt = r_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= RESET_VAL;
      end else begin
         r_q <= w_nxt;
      end
   end

   assign q     = r_q;
   assign qn    = ~r_q;
   assign s_exc = w_nxt & ~r_q;
   assign r_exc = ~w_nxt & r_q;

`ifdef FF_MODE_SR_CHECK_EN
   logic r_err;
   logic w_illegal;

   assign w_illegal = en && (mode == c_MODE_SR) && (|(a & b));

   // a fresh illegal sample outranks a clear on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_illegal) begin
         r_err <= 1'b1;
      end else if (err_clr) begin
         r_err <= 1'b0;
      end
   end

   assign err = r_err;
`else
   logic w_unused_err_clr;

   assign w_unused_err_clr = err_clr;
   assign err              = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ff_mode_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ff_mode_bank
//  Description : Directed and randomised self-checking bench for ff_mode_bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ff_mode_bank;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [7:0] a;
   logic [7:0] b;
   logic       err_clr;
   logic [7:0] q;
   logic [7:0] qn;
   logic [7:0] s_exc;
   logic [7:0] r_exc;
   logic       err;

   int total;
   int bad;

   ff_mode_bank #(
      .WIDTH     (8),
      .RESET_VAL (8'hA5)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .a       (a),
      .b       (b),
      .err_clr (err_clr),
      .q       (q),
      .qn      (qn),
      .s_exc   (s_exc),
      .r_exc   (r_exc),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference next-state, written bit by bit from the flip-flop truth tables
   function automatic logic [7:0] model_nxt(input logic e, input logic [1:0] m,
                                            input logic [7:0] ai, input logic [7:0] bi,
                                            input logic [7:0] qi);
      logic [7:0] n;
      for (int i = 0; i < 8; i++) begin
         if (!e) n[i] = qi[i];
         else begin
            case (m)
               2'b00: n[i] = ai[i];
               2'b01: n[i] = qi[i] ^ ai[i];
               2'b10: begin
                  case ({ai[i], bi[i]})
                     2'b00: n[i] = qi[i];
                     2'b10: n[i] = 1'b1;
                     2'b01: n[i] = 1'b0;
                     default: n[i] = ~qi[i];
                  endcase
               end
               default: begin
                  case ({ai[i], bi[i]})
                     2'b00: n[i] = qi[i];
                     2'b10: n[i] = 1'b1;
                     2'b01: n[i] = 1'b0;
`ifdef FF_MODE_SR_CHECK_EN
                     default: n[i] = qi[i];
`else
                     default: n[i] = 1'b0;
`endif
                  endcase
               end
            endcase
         end
      end
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] v);
      rst = 1'b0; en = 1'b1; mode = 2'b00; a = v; b = 8'h00; err_clr = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; err_clr = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mode = 2'($urandom_range(0, 3));
         a    = 8'($urandom);
         b    = 8'($urandom);
         tick();
      end
      total++; if (q !== 8'hA5) begin bad++; $display("FAIL reset_q got=%h exp=a5", q); end
      total++; if (qn !== 8'h5A) begin bad++; $display("FAIL reset_qn got=%h exp=5a", qn); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      rst = 1'b0; mode = 2'b00; a = 8'h00; b = 8'h00;
      #1;
      total++; if (r_exc !== 8'hA5 || s_exc !== 8'h00) begin
         bad++; $display("FAIL reset_exc got s=%h r=%h exp s=00 r=a5", s_exc, r_exc);
      end
      tick();
      total++; if (q !== 8'h00) begin bad++; $display("FAIL first_update got=%h exp=00", q); end
   endtask

   task automatic test_d_t();
      load(8'h00);
      mode = 2'b00; a = 8'h3C;
      tick();
      total++; if (q !== 8'h3C) begin bad++; $display("FAIL d_mode got=%h exp=3c", q); end
      mode = 2'b01; a = 8'h0F;
      tick();
      total++; if (q !== 8'h33) begin bad++; $display("FAIL t_mode1 got=%h exp=33", q); end
      tick();
      total++; if (q !== 8'h3C) begin bad++; $display("FAIL t_mode2 got=%h exp=3c", q); end
   endtask

   task automatic test_hold();
      en = 1'b0; mode = 2'b01; a = 8'hFF; b = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (s_exc !== 8'h00 || r_exc !== 8'h00) begin
            bad++; $display("FAIL hold_exc got s=%h r=%h exp 00/00", s_exc, r_exc);
         end
         tick();
         total++; if (q !== 8'h3C) begin bad++; $display("FAIL hold_q got=%h exp=3c", q); end
      end
      total++; if (qn !== 8'hC3) begin bad++; $display("FAIL hold_qn got=%h exp=c3", qn); end
   endtask

   task automatic test_jk();
      load(8'hF0);
      mode = 2'b10; a = 8'hCC; b = 8'hAA;
      #1;
      total++; if (s_exc !== 8'h0C) begin bad++; $display("FAIL jk_s_exc got=%h exp=0c", s_exc); end
      total++; if (r_exc !== 8'hA0) begin bad++; $display("FAIL jk_r_exc got=%h exp=a0", r_exc); end
      tick();
      total++; if (q !== 8'h5C) begin bad++; $display("FAIL jk_q got=%h exp=5c", q); end
   endtask

   task automatic test_mid_reset();
      load(8'h12);
      rst = 1'b1; en = 1'b1; mode = 2'b00; a = 8'hFF;
      tick();
      total++; if (q !== 8'hA5) begin bad++; $display("FAIL mid_reset got=%h exp=a5", q); end
      rst = 1'b0;
   endtask

   task automatic test_excitation();
      logic [7:0] q_prev, s_prev, r_prev, exp_q;
      logic       exp_err, ill;
      int         nfail;
      rst = 1'b1; en = 1'b1; err_clr = 1'b0;
      tick();
      rst = 1'b0;
      exp_q = 8'hA5; exp_err = 1'b0; nfail = 0;
      for (int i = 0; i < 1000; i++) begin
         en      = ($urandom_range(0, 7) != 0);
         mode    = 2'($urandom_range(0, 3));
         a       = 8'($urandom);
         b       = 8'($urandom);
         err_clr = ($urandom_range(0, 3) == 0);
         #1;
         q_prev = q; s_prev = s_exc; r_prev = r_exc;
         total++; if ((s_exc & r_exc) !== 8'h00) begin
            bad++; nfail++;
            if (nfail < 10) $display("FAIL exc_overlap got=%h exp=00", s_exc & r_exc);
         end
         ill = en && (mode == 2'b11) && (|(a & b));
         exp_q = model_nxt(en, mode, a, b, exp_q);
`ifdef FF_MODE_SR_CHECK_EN
         if (ill) exp_err = 1'b1;
         else if (err_clr) exp_err = 1'b0;
`else
         ill = 1'b0;
         exp_err = ill;
`endif
         tick();
         total++; if (q !== ((q_prev | s_prev) & ~r_prev)) begin
            bad++; nfail++;
            if (nfail < 10) $display("FAIL exc_consistency got=%h exp=%h", q, (q_prev | s_prev) & ~r_prev);
         end
         total++; if (q !== exp_q || err !== exp_err) begin
            bad++; nfail++;
            if (nfail < 10) $display("FAIL rand_model got q=%h err=%b exp q=%h err=%b", q, err, exp_q, exp_err);
         end
      end
      err_clr = 1'b0;
   endtask

   task automatic test_sr_illegal();
      logic [7:0] e_q, e_r;
      logic       e_err1, e_err3;
      rst = 1'b1; tick();
      load(8'h0F);
`ifdef FF_MODE_SR_CHECK_EN
      e_q = 8'h8F; e_r = 8'h00; e_err1 = 1'b1; e_err3 = 1'b1;
`else
      e_q = 8'h8E; e_r = 8'h01; e_err1 = 1'b0; e_err3 = 1'b0;
`endif
      mode = 2'b11; a = 8'h81; b = 8'h01; err_clr = 1'b0;
      #1;
      total++; if (s_exc !== 8'h80 || r_exc !== e_r) begin
         bad++; $display("FAIL sr_exc got s=%h r=%h exp s=80 r=%h", s_exc, r_exc, e_r);
      end
      tick();
      total++; if (q !== e_q) begin bad++; $display("FAIL sr_q got=%h exp=%h", q, e_q); end
      total++; if (err !== e_err1) begin bad++; $display("FAIL sr_err_set got=%b exp=%b", err, e_err1); end
      a = 8'h00; b = 8'h00; err_clr = 1'b1;
      tick();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL sr_err_clr got=%b exp=0", err); end
      a = 8'h81; b = 8'h01;
      tick();
      total++; if (err !== e_err3) begin bad++; $display("FAIL sr_set_wins got=%b exp=%b", err, e_err3); end
      total++; if (q !== e_q) begin bad++; $display("FAIL sr_q_final got=%h exp=%h", q, e_q); end
      // err holds while disabled
      en = 1'b0; err_clr = 1'b0;
      tick();
      total++; if (err !== e_err3) begin bad++; $display("FAIL sr_err_hold got=%b exp=%b", err, e_err3); end
      err_clr = 1'b0; en = 1'b1;
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; en = 1'b0; mode = 2'b00; a = 8'h00; b = 8'h00; err_clr = 1'b0;
      #2;
      test_reset();
      test_d_t();
      test_hold();
      test_jk();
      test_mid_reset();
      test_excitation();
      test_sr_illegal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ff_mode_bank.md
# ff_mode_bank

Parametrised multi-mode flip-flop register bank: WIDTH independent bits, each updated on the rising clock edge as a D, T, JK or SR flip-flop, chosen by a shared run-time mode input. It sits wherever the design needs a configurable state register. It also exports, combinationally, the SR excitation pair that would drive each bit to its next state, so flip-flop-type conversion can be checked in-circuit. Out-of-range SR inputs are detected and flagged.

## Interface
- WIDTH, 8, number of flip-flop bits (1..64)
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  update enable; 0 = all bits hold
- mode  input  2  00 D, 01 T, 10 JK, 11 SR
- a  input  WIDTH  D / T / J / S per bit, depending on mode
- b  input  WIDTH  K / R per bit (ignored in D and T modes)
- err_clr  input  1  clears the sticky error flag
- q  output  WIDTH  registered state
- qn  output  WIDTH  ~q (combinational)
- s_exc  output  WIDTH  SR set excitation for the next state
- r_exc  output  WIDTH  SR reset excitation for the next state
- err  output  1  sticky illegal-SR flag (registered)

## Operation
- Per-bit next-state function `nxt`, computed combinationally from mode, a, b and q:
  - D: nxt = a
  - T: nxt = q ^ a
  - JK: nxt = (a & ~q) | (~b & q); J=K=1 toggles the bit.
  - SR: S=1,R=0 → 1; S=0,R=1 → 0; S=R=0 → hold; S=R=1 is illegal (see Configuration).
- When en=0, nxt = q for every bit, regardless of mode.
- On each posedge with rst=0 and en=1, q <= nxt.
- `s_exc = nxt & ~q`, `r_exc = ~nxt & q`.
  - These are never both 1 on the same bit.
  - Both are 0 when a bit holds.
- `qn = ~q` at all times.
- `mode` is sampled each cycle. Changing mode between cycles is legal and takes effect on that edge; there is no pipeline and no latency beyond one register.
- Reset:
  - Has priority over en, mode and err_clr.
  - q = RESET_VAL, qn = ~RESET_VAL, err = 0.
  - After reset, s_exc and r_exc follow from the inputs and q = RESET_VAL.
  - Reset asserted mid-operation discards the pending update on that edge.

## Timing
- q and err are registered: an input sampled at edge n is visible on q after edge n.
- qn, s_exc and r_exc are combinational from the current inputs and current q. They settle within the same cycle, ahead of edge n+1.
- err flag:
  - Sets on the edge that samples an illegal SR condition (en=1, mode=11, any bit with a=b=1).
  - err_clr=1 on an edge clears err.
  - If a new illegal condition is sampled on the same edge as err_clr, set wins and err stays 1.
- With en=0, no SR illegal detection occurs and err holds.

## Configuration
- Macro: `FF_MODE_SR_CHECK_EN`.
- Defined:
  - A bit with S=R=1 in SR mode holds its value: nxt = q, s_exc = r_exc = 0.
  - err is set as described in Timing.
- Undefined:
  - S=R=1 is reset-dominant: nxt = 0 for that bit, and r_exc follows from the normal rule.
  - err is tied to 0.
  - err_clr is ignored.
  - No detection logic is synthesised.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5; hold rst=1 for 2 cycles with random a, b, mode, en=1 → q=8'hA5, qn=8'h5A, err=0. Release rst → the first update occurs on the next edge.
- D/T modes:
  - From q=8'h00, mode=00, a=8'h3C → q=8'h3C after 1 edge.
  - Then mode=01, a=8'h0F → q=8'h33; one more edge → q=8'h3C.
  - With en=0 → q holds for 3 edges, and s_exc=r_exc=0.
- JK mode: from q=8'hF0, mode=10, a=8'hCC, b=8'hAA → the per-bit results are:
  - J=K=1 toggles.
  - J=1,K=0 sets.
  - J=0,K=1 clears.
  - J=K=0 holds.
  
  Expected q=8'h5C. Before the edge, s_exc=8'h0C and r_exc=8'hA0.
- Excitation check: for 1000 random cycles in all modes, check s_exc & r_exc == 0. Also check that q after the edge equals (q | s_exc) & ~r_exc from before the edge.
- SR illegal, macro defined: from q=8'h0F, mode=11, a=8'h81, b=8'h01 → bit7 sets, bit0 holds, giving q=8'h8F, and err=1 after the edge.
  - Then err_clr=1 with legal inputs → err=0.
  - err_clr=1 with the illegal inputs still applied → err stays 1.
- SR illegal, macro undefined: same stimulus → q=8'h8E, and err stays 0 throughout.
